cardinal_store_buffer: RTL and testbench

Write-back store buffer between the cardinal pipeline's EX-stage memory port and the single-ported data memory. Stores are queued and drained to memory when the memory port is not needed by a load. Loads that hit a queued store get their data forwarded, aligned to the WB-stage read timing. `cpu_stall` holds the pipeline when the buffer is full or memory refuses a load.

---
 rtl/cardinal_store_buffer.sv | 139 +++++++++++++
 tb/tb_cardinal_store_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cardinal_store_buffer.sv
// Write-back store buffer between the EX-stage memory port and single-ported data memory.
// Optional in-place store merging is enabled by defining STORE_COALESCE_EN.
module cardinal_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_memEn,
    input  logic              cpu_memWrEn,
    input  logic [ADDR_W-1:0] cpu_memAddr,
    input  logic [DATA_W-1:0] cpu_dataOut,
    output logic [DATA_W-1:0] cpu_dataIn,
    output logic              cpu_stall,
    output logic              mem_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              sb_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              hit_q;
    logic [DATA_W-1:0] fwd_q;

    logic              is_store, is_load, nonempty, full;
    logic              load_hit, load_miss, drain_fire;
    logic              coal_hit, store_accept, alloc, load_accept;
    logic [DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]  slot, coal_slot;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        is_store  = cpu_memEn & cpu_memWrEn;
        is_load   = cpu_memEn & ~cpu_memWrEn;
        nonempty  = (count_q != '0);
        full      = (count_q == CNT_W'(DEPTH));
        load_hit  = 1'b0;
        fwd_data  = '0;
        slot      = '0;
        coal_hit  = 1'b0;
        coal_slot = '0;

        // Walk oldest to youngest so the last match is the youngest entry.
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_q + PTR_W'(k);
            if (is_load && CNT_W'(k) < count_q && addr_q[slot] == cpu_memAddr) begin
                load_hit = 1'b1;
                fwd_data = data_q[slot];
            end
        end

        load_miss  = is_load & ~load_hit;
        drain_fire = ~reset & ~load_miss & nonempty & mem_ready;

`ifdef STORE_COALESCE_EN
        // The head leaving this cycle cannot absorb a merge; such a store allocates.
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_q + PTR_W'(k);
            if (is_store && !reset && CNT_W'(k) < count_q && addr_q[slot] == cpu_memAddr
                && !(drain_fire && k == 0)) begin
                coal_hit  = 1'b1;
                coal_slot = slot;
            end
        end
`endif

        cpu_stall    = ~reset & ((load_miss & ~mem_ready)
                                 | (is_store & full & ~drain_fire & ~coal_hit));
        store_accept = ~reset & is_store & ~cpu_stall;
        alloc        = store_accept & ~coal_hit;
        load_accept  = ~reset & is_load & ~cpu_stall;

        head_d  = drain_fire ? head_q + PTR_W'(1) : head_q;
        tail_d  = alloc ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(alloc) - CNT_W'(drain_fire);
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (load_miss) begin
                mem_en   = 1'b1;
                mem_addr = cpu_memAddr;
            end else if (nonempty) begin
                mem_en    = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = addr_q[head_q];
                mem_wdata = data_q[head_q];
            end
        end
    end

    assign sb_empty   = reset | ~nonempty;
    assign cpu_dataIn = hit_q ? fwd_q : mem_rdata;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            hit_q   <= 1'b0;
            fwd_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            hit_q   <= load_accept & load_hit;
            if (load_accept && load_hit) begin
                fwd_q <= fwd_data;
            end
        end
    end

    // NOTE: the entry array is not reset; count/pointers alone decide which slots are valid.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[tail_q] <= cpu_memAddr;
            data_q[tail_q] <= cpu_dataOut;
        end else if (coal_hit) begin
            data_q[coal_slot] <= cpu_dataOut;
        end
    end

endmodule

// File: tb/tb_cardinal_store_buffer.sv
// Self-checking bench for cardinal_store_buffer: directed vector table, corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_cardinal_store_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
`ifdef STORE_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_memEn = 1'b0;
    logic              cpu_memWrEn = 1'b0;
    logic [ADDR_W-1:0] cpu_memAddr = '0;
    logic [DATA_W-1:0] cpu_dataOut = '0;
    logic [DATA_W-1:0] cpu_dataIn;
    logic              cpu_stall;
    logic              mem_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;
    logic              sb_empty;

    cardinal_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_memEn  (cpu_memEn),
        .cpu_memWrEn(cpu_memWrEn),
        .cpu_memAddr(cpu_memAddr),
        .cpu_dataOut(cpu_dataOut),
        .cpu_dataIn (cpu_dataIn),
        .cpu_stall  (cpu_stall),
        .mem_en     (mem_en),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .sb_empty   (sb_empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is simply an ordered list of pending {addr, data}.
    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } ent_t;

    ent_t        q[$];
    bit          m_hit_q = 1'b0;
    logic [63:0] m_fwd_q = '0;

    // Drive one cycle at the falling edge, check outputs just after, then advance the model.
    task automatic cycle(input logic en, input logic wr, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic ready,
                         input logic [63:0] rdata, input logic rst);
        int          hit_idx, coal_idx;
        bit          st, ld, hit, miss, drain, stall;
        logic        x_men, x_mwr;
        logic [31:0] x_maddr;
        logic [63:0] x_mwdata, x_din;
        @(negedge clk);
        reset       = rst;
        cpu_memEn   = en;
        cpu_memWrEn = wr;
        cpu_memAddr = addr;
        cpu_dataOut = wdata;
        mem_ready   = ready;
        mem_rdata   = rdata;
        #1;
        st = en && wr;
        ld = en && !wr;
        hit_idx = -1;
        foreach (q[i]) if (q[i].addr == addr) hit_idx = i;
        hit  = ld && hit_idx >= 0;
        miss = ld && hit_idx < 0;
        x_men = 1'b0; x_mwr = 1'b0; x_maddr = '0; x_mwdata = '0;
        if (!rst) begin
            if (miss) begin
                x_men = 1'b1; x_maddr = addr;
            end else if (q.size() > 0) begin
                x_men = 1'b1; x_mwr = 1'b1; x_maddr = q[0].addr; x_mwdata = q[0].data;
            end
        end
        drain = !rst && !miss && q.size() > 0 && ready;
        coal_idx = -1;
        if (COALESCE && st && !rst)
            foreach (q[i]) if (q[i].addr == addr && !(drain && i == 0)) coal_idx = i;
        stall = !rst && ((miss && !ready) ||
                         (st && q.size() == DEPTH && !drain && coal_idx < 0));
        x_din = m_hit_q ? m_fwd_q : rdata;

        check("mem_en", mem_en, x_men);
        check("mem_wr_en", mem_wr_en, x_mwr);
        check("mem_addr", mem_addr, x_maddr);
        check("mem_wdata", mem_wdata, x_mwdata);
        check("cpu_stall", cpu_stall, stall);
        check("sb_empty", sb_empty, rst || q.size() == 0);
        check("cpu_dataIn", cpu_dataIn, x_din);

        if (rst) begin
            q.delete();
            m_hit_q = 1'b0;
            m_fwd_q = '0;
        end else begin
            m_hit_q = ld && !stall && hit;
            if (m_hit_q) m_fwd_q = q[hit_idx].data;
            if (coal_idx >= 0) q[coal_idx].data = wdata;
            if (drain) void'(q.pop_front());
            if (st && !stall && coal_idx < 0) q.push_back('{addr, wdata});
        end
    endtask

    task automatic idle(input logic ready);
        cycle(1'b0, 1'b0, '0, '0, ready, {$urandom, $urandom}, 1'b0);
    endtask

    task automatic flush();
        for (int i = 0; i < 2 * DEPTH + 2 && q.size() > 0; i++) idle(1'b1);
        idle(1'b1);
        check("flush_empty", sb_empty, 1'b1);
    endtask

    typedef struct {
        logic        en, wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic        ready;
        logic [63:0] rdata;
        logic        x_stall, x_men, x_mwr;
        logic [31:0] x_maddr;
        logic [63:0] x_mwdata;
        logic        x_empty;
        logic [63:0] x_din;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [63:0] head20;
        head20 = COALESCE ? 64'hBBBB : 64'hAAAA;
        //              en wr addr   wdata    rdy rdata      stl men mwr maddr  mwdata   emp din
        tbl[0]  = '{1, 1, 32'h10, 64'h1111, 1, 64'hD0,     0, 0, 0, 32'h0,  64'h0,    1, 64'hD0};
        tbl[1]  = '{0, 0, 32'h0,  64'h0,    1, 64'hD1,     0, 1, 1, 32'h10, 64'h1111, 0, 64'hD1};
        tbl[2]  = '{0, 0, 32'h0,  64'h0,    1, 64'hD2,     0, 0, 0, 32'h0,  64'h0,    1, 64'hD2};
        tbl[3]  = '{1, 0, 32'h30, 64'h0,    0, 64'hD3,     1, 1, 0, 32'h30, 64'h0,    1, 64'hD3};
        tbl[4]  = '{1, 0, 32'h30, 64'h0,    0, 64'hD4,     1, 1, 0, 32'h30, 64'h0,    1, 64'hD4};
        tbl[5]  = '{1, 0, 32'h30, 64'h0,    1, 64'hD5,     0, 1, 0, 32'h30, 64'h0,    1, 64'hD5};
        tbl[6]  = '{0, 0, 32'h0,  64'h0,    1, 64'hCAFE,   0, 0, 0, 32'h0,  64'h0,    1, 64'hCAFE};
        tbl[7]  = '{1, 1, 32'h20, 64'hAAAA, 0, 64'hD7,     0, 0, 0, 32'h0,  64'h0,    1, 64'hD7};
        tbl[8]  = '{1, 1, 32'h20, 64'hBBBB, 0, 64'hD8,     0, 1, 1, 32'h20, 64'hAAAA, 0, 64'hD8};
        tbl[9]  = '{1, 0, 32'h20, 64'h0,    0, 64'hD9,     0, 1, 1, 32'h20, head20,   0, 64'hD9};
        tbl[10] = '{0, 0, 32'h0,  64'h0,    1, 64'hDA,     0, 1, 1, 32'h20, head20,   0, 64'hBBBB};

        cycle(0, 0, '0, '0, 1'b0, '0, 1'b1);
        cycle(0, 0, '0, '0, 1'b1, '0, 1'b1);

        foreach (tbl[i]) begin
            cycle(tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].ready, tbl[i].rdata, 1'b0);
            check($sformatf("v%0d.stall", i), cpu_stall, tbl[i].x_stall);
            check($sformatf("v%0d.mem_en", i), mem_en, tbl[i].x_men);
            check($sformatf("v%0d.mem_wr_en", i), mem_wr_en, tbl[i].x_mwr);
            check($sformatf("v%0d.mem_addr", i), mem_addr, tbl[i].x_maddr);
            check($sformatf("v%0d.mem_wdata", i), mem_wdata, tbl[i].x_mwdata);
            check($sformatf("v%0d.sb_empty", i), sb_empty, tbl[i].x_empty);
            check($sformatf("v%0d.dataIn", i), cpu_dataIn, tbl[i].x_din);
        end
        flush();

        // Full buffer: fifth store stalls until a drain frees the head in the same cycle.
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, 32'h40 + i, 64'h4000 + i, 1'b0, '0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle(1, 1, 32'h44, 64'h4004, 1'b0, '0, 1'b0);
            check("full_stall", cpu_stall, 1'b1);
        end
        cycle(1, 1, 32'h44, 64'h4004, 1'b1, '0, 1'b0);
        check("full_drain_accept_stall", cpu_stall, 1'b0);
        check("full_drain_addr", mem_addr, 32'h40);
        cycle(1, 1, 32'h45, 64'h4005, 1'b0, '0, 1'b0);
        check("full_still_full", cpu_stall, 1'b1);
        check("full_new_head", mem_addr, 32'h41);
        flush();

        // Load misses own the port; drains only in idle cycles, in FIFO order.
        for (int i = 0; i < 3; i++) cycle(1, 1, 32'h50 + i, 64'h5000 + i, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 32'h60 + i, '0, 1'b1, '0, 1'b0);
            check("alt_load_wr", mem_wr_en, 1'b0);
            check("alt_load_addr", mem_addr, 32'h60 + i);
            idle(1'b1);
            check("alt_drain_wr", mem_wr_en, 1'b1);
            check("alt_drain_addr", mem_addr, 32'h50 + i);
            check("alt_drain_data", mem_wdata, 64'h5000 + i);
        end
        idle(1'b1);
        check("alt_empty", sb_empty, 1'b1);

        // Reset in the middle of draining discards the queue.
        for (int i = 0; i < 3; i++) cycle(1, 1, 32'h70 + i, 64'h7000 + i, 1'b0, '0, 1'b0);
        idle(1'b1);
        cycle(0, 0, '0, '0, 1'b1, '0, 1'b1);
        check("rst_mem_en", mem_en, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            check("post_rst_empty", sb_empty, 1'b1);
            check("post_rst_mem_en", mem_en, 1'b0);
        end

        // Randomized traffic on a small address set to provoke hits, merges and full stalls.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1), 32'($urandom_range(0, 5)),
                  {$urandom, $urandom}, $urandom_range(0, 3) != 0, {$urandom, $urandom},
                  $urandom_range(0, 63) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
